// File: rtl/fase_pkg.sv
// Shared phase constants, decoder state encoding and the phase-rotate helper.
package fase_pkg;

  localparam int FASE_W = 5;

  localparam logic [FASE_W-1:0] F_IF  = 5'b00001;
  localparam logic [FASE_W-1:0] F_ID  = 5'b00010;
  localparam logic [FASE_W-1:0] F_EX  = 5'b00100;
  localparam logic [FASE_W-1:0] F_MEM = 5'b01000;
  localparam logic [FASE_W-1:0] F_WB  = 5'b10000;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RUN       = 3'd1,
    ST_HALT_PEND = 3'd2,
    ST_HALTED    = 3'd3,
    ST_ERROR     = 3'd4
  } state_t;

  // Expected successor of a phase word; WB wraps back to IF.
  function automatic logic [FASE_W-1:0] fase_rotl(input logic [FASE_W-1:0] v);
    return {v[FASE_W-2:0], v[FASE_W-1]};
  endfunction

endpackage

// File: rtl/fase_legal_chk.sv
// Combinational legality check of one phase word against the previous one.
module fase_legal_chk
  import fase_pkg::*;
(
  input  logic [FASE_W-1:0] in_fase,
  input  logic [FASE_W-1:0] prev_q,
  output logic              onehot,
  output logic              succ_ok,
  output logic              is_zero,
  output logic              is_wb
);

  logic [FASE_W-1:0] w_lowered;

  // Clearing the lowest set bit leaves zero only for a single-bit word.
  assign w_lowered = in_fase & (in_fase - 5'd1);
  assign is_zero   = (in_fase == '0);
  assign onehot    = !is_zero && (w_lowered == '0);
  assign succ_ok   = (in_fase == fase_rotl(prev_q));
  assign is_wb     = (in_fase == F_WB);

endmodule

// File: rtl/fase_decoder.sv
// Phase-bus consumer: checks one-hot phase words, issues registered stage
// strobes, counts retires and handles halt. Optional: FASE_DECODER_RECOVER_EN.
module fase_decoder
  import fase_pkg::*;
#(
  parameter int PHASES = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PHASES-1:0] in_fase,
  input  logic              halt_req,
  output logic [PHASES-1:0] stage_en,
  output logic [CNT_W-1:0]  retire_cnt,
  output logic              halted,
  output logic              fase_err,
  output logic [2:0]        state_o
);

  state_t            r_state;
  logic [PHASES-1:0] r_prev_q;
  logic [PHASES-1:0] r_stage_en;
  logic [CNT_W-1:0]  r_retire_cnt;
  logic              r_halted;
  logic              r_fase_err;

  state_t            w_state_nxt;
  logic [PHASES-1:0] w_stage_nxt;
  logic              w_cnt_inc;
  logic              w_halted_nxt;
  logic              w_err_nxt;
  logic              w_prev_ld;
  logic              w_legal;
  logic              w_onehot;
  logic              w_succ_ok;
  logic              w_is_zero;
  logic              w_is_wb;

  fase_legal_chk u_legal (
    .in_fase (in_fase),
    .prev_q  (r_prev_q),
    .onehot  (w_onehot),
    .succ_ok (w_succ_ok),
    .is_zero (w_is_zero),
    .is_wb   (w_is_wb)
  );

  assign w_legal = w_onehot && w_succ_ok;

`ifdef FASE_DECODER_RECOVER_EN
  assign w_prev_ld = 1'b1;
`else
  // The last good phase stays frozen once the bus has been declared broken.
  assign w_prev_ld = (r_state != ST_ERROR);
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_stage_nxt  = '0;
    w_cnt_inc    = 1'b0;
    w_halted_nxt = 1'b0;
    w_err_nxt    = r_fase_err;
    case (r_state)
      ST_IDLE: begin
        if (in_fase == F_IF) begin
          w_state_nxt = ST_RUN;
          w_stage_nxt = F_IF;
        end else if (!w_is_zero && !w_onehot) begin
          w_state_nxt = ST_ERROR;
          w_err_nxt   = 1'b1;
        end
      end
      ST_RUN, ST_HALT_PEND: begin
        if (w_legal) begin
          w_stage_nxt = in_fase;
          w_cnt_inc   = w_is_wb;
          // A pending halt latches until WB, even if the request drops.
          if (w_is_wb && (r_state == ST_HALT_PEND || halt_req))
            w_state_nxt = ST_HALTED;
          else if (halt_req)
            w_state_nxt = ST_HALT_PEND;
        end else begin
          w_state_nxt = ST_ERROR;
          w_err_nxt   = 1'b1;
        end
      end
      ST_HALTED: begin
        if (!w_legal) begin
          w_state_nxt = ST_ERROR;
          w_err_nxt   = 1'b1;
        end else if (!halt_req) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_halted_nxt = 1'b1;
        end
      end
      ST_ERROR: begin
`ifdef FASE_DECODER_RECOVER_EN
        if (in_fase == F_IF) begin
          w_state_nxt = ST_RUN;
          w_stage_nxt = F_IF;
          w_err_nxt   = 1'b0;
        end
`endif
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_prev_q     <= '0;
      r_stage_en   <= '0;
      r_retire_cnt <= '0;
      r_halted     <= 1'b0;
      r_fase_err   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_stage_en <= w_stage_nxt;
      r_halted   <= w_halted_nxt;
      r_fase_err <= w_err_nxt;
      if (w_prev_ld)
        r_prev_q <= in_fase;
      if (w_cnt_inc)
        r_retire_cnt <= r_retire_cnt + CNT_W'(1);
    end
  end

  assign stage_en   = r_stage_en;
  assign retire_cnt = r_retire_cnt;
  assign halted     = r_halted;
  assign fase_err   = r_fase_err;
  assign state_o    = r_state;

endmodule

// File: tb/tb_fase_decoder.sv
// Directed bench for fase_decoder with a 4-bit retire counter to reach wrap quickly.
module tb_fase_decoder;

  localparam int CNT_W = 4;

  localparam logic [4:0] P_IF  = 5'b00001;
  localparam logic [4:0] P_ID  = 5'b00010;
  localparam logic [4:0] P_EX  = 5'b00100;
  localparam logic [4:0] P_MEM = 5'b01000;
  localparam logic [4:0] P_WB  = 5'b10000;

  logic             clk;
  logic             rst;
  logic [4:0]       in_fase;
  logic             halt_req;
  logic [4:0]       stage_en;
  logic [CNT_W-1:0] retire_cnt;
  logic             halted;
  logic             fase_err;
  logic [2:0]       state_o;

  int n_checks = 0;
  int n_errors = 0;

  fase_decoder #(.PHASES(5), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_fase    (in_fase),
    .halt_req   (halt_req),
    .stage_en   (stage_en),
    .retire_cnt (retire_cnt),
    .halted     (halted),
    .fase_err   (fase_err),
    .state_o    (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [4:0] f, input logic h);
    in_fase  = f;
    halt_req = h;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #3;
    rst = 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stage"}, 32'(stage_en), 32'h0);
    chk({tag, "_cnt"},   32'(retire_cnt), 32'h0);
    chk({tag, "_halted"}, 32'(halted), 32'h0);
    chk({tag, "_err"},   32'(fase_err), 32'h0);
    chk({tag, "_state"}, 32'(state_o), 32'h0);
  endtask

  initial begin
    logic [4:0] seq [5];
    seq[0] = P_IF; seq[1] = P_ID; seq[2] = P_EX; seq[3] = P_MEM; seq[4] = P_WB;
    rst = 1'b0;
    in_fase = '0;
    halt_req = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk_all_zero("reset");
    rst = 1'b1;

    // Three full instructions: strobe follows the bus one clock later.
    step(5'b00000, 1'b0);
    chk("idle_zero_state", 32'(state_o), 32'd0);
    chk("idle_zero_stage", 32'(stage_en), 32'h0);
    for (int n = 0; n < 3; n++) begin
      for (int k = 0; k < 5; k++) begin
        step(seq[k], 1'b0);
        chk($sformatf("run_stage_%0d_%0d", n, k), 32'(stage_en), 32'(seq[k]));
      end
    end
    chk("run_cnt3", 32'(retire_cnt), 32'd3);
    chk("run_err", 32'(fase_err), 32'd0);
    chk("run_state", 32'(state_o), 32'd1);

    // Halt raised during EX, dropped during MEM: halt still completes at WB.
    step(P_IF, 1'b0);
    step(P_ID, 1'b0);
    step(P_EX, 1'b1);
    chk("hp_state", 32'(state_o), 32'd2);
    chk("hp_stage_ex", 32'(stage_en), 32'(P_EX));
    step(P_MEM, 1'b0);
    chk("hp_stage_mem", 32'(stage_en), 32'(P_MEM));
    chk("hp_state_mem", 32'(state_o), 32'd2);
    step(P_WB, 1'b1);
    chk("hp_stage_wb", 32'(stage_en), 32'(P_WB));
    chk("hp_cnt4", 32'(retire_cnt), 32'd4);
    chk("hp_state_halted", 32'(state_o), 32'd3);
    step(P_IF, 1'b1);
    chk("h_halted", 32'(halted), 32'd1);
    chk("h_stage0", 32'(stage_en), 32'h0);
    step(P_ID, 1'b1);
    chk("h_halted2", 32'(halted), 32'd1);
    chk("h_stage0b", 32'(stage_en), 32'h0);
    step(P_EX, 1'b0);
    chk("h_release_state", 32'(state_o), 32'd0);
    chk("h_release_halted", 32'(halted), 32'd0);
    step(P_MEM, 1'b0);
    step(P_WB, 1'b0);
    chk("h_idle_no_wb", 32'(stage_en), 32'h0);
    chk("h_idle_cnt", 32'(retire_cnt), 32'd4);
    step(P_IF, 1'b0);
    chk("resume_state", 32'(state_o), 32'd1);
    chk("resume_stage", 32'(stage_en), 32'(P_IF));

    // Halt requested on the WB cycle itself.
    step(P_ID, 1'b0);
    step(P_EX, 1'b0);
    step(P_MEM, 1'b0);
    step(P_WB, 1'b1);
    chk("hwb_stage", 32'(stage_en), 32'(P_WB));
    chk("hwb_cnt5", 32'(retire_cnt), 32'd5);
    chk("hwb_state", 32'(state_o), 32'd3);
    step(P_IF, 1'b1);
    chk("hwb_halted", 32'(halted), 32'd1);
    step(P_ID, 1'b0);
    chk("hwb_idle", 32'(state_o), 32'd0);
    step(P_EX, 1'b0);
    step(P_MEM, 1'b0);
    step(P_WB, 1'b0);

    // Mid-instruction one-hot word in IDLE is ignored; then an illegal jump.
    step(P_EX, 1'b0);
    chk("resync_state", 32'(state_o), 32'd0);
    chk("resync_stage", 32'(stage_en), 32'h0);
    chk("resync_err", 32'(fase_err), 32'd0);
    step(P_IF, 1'b0);
    step(P_ID, 1'b0);
    step(P_MEM, 1'b0);
    chk("jump_state", 32'(state_o), 32'd4);
    chk("jump_err", 32'(fase_err), 32'd1);
    chk("jump_stage", 32'(stage_en), 32'h0);
    step(P_EX, 1'b0);
    step(P_MEM, 1'b0);
    step(P_WB, 1'b0);
    chk("err_hold_state", 32'(state_o), 32'd4);
    chk("err_hold_cnt", 32'(retire_cnt), 32'd5);
    step(P_IF, 1'b0);
`ifdef FASE_DECODER_RECOVER_EN
    chk("err_exit_state", 32'(state_o), 32'd1);
    chk("err_exit_err", 32'(fase_err), 32'd0);
    chk("err_exit_stage", 32'(stage_en), 32'(P_IF));
`else
    chk("err_sticky_state", 32'(state_o), 32'd4);
    chk("err_sticky_err", 32'(fase_err), 32'd1);
    chk("err_sticky_stage", 32'(stage_en), 32'h0);
`endif

    // Reset clears the error; a multi-bit word in IDLE is a protocol error.
    do_reset();
    chk_all_zero("rst2");
    step(5'b00110, 1'b0);
    chk("multi_state", 32'(state_o), 32'd4);
    chk("multi_err", 32'(fase_err), 32'd1);
    do_reset();
    step(5'b00000, 1'b0);
    step(P_EX, 1'b0);
    chk("idle_ex_state", 32'(state_o), 32'd0);
    chk("idle_ex_stage", 32'(stage_en), 32'h0);

    // Counter wrap across 17 instructions with a 4-bit counter.
    for (int n = 0; n < 17; n++) begin
      for (int k = 0; k < 5; k++) step(seq[k], 1'b0);
      if (n == 14) chk("wrap_cnt15", 32'(retire_cnt), 32'd15);
      if (n == 15) chk("wrap_cnt0", 32'(retire_cnt), 32'd0);
    end
    chk("wrap_cnt1", 32'(retire_cnt), 32'd1);

    // Asynchronous reset mid-EX, sampled before any further clock edge.
    step(P_IF, 1'b0);
    step(P_ID, 1'b0);
    step(P_EX, 1'b0);
    chk("midex_stage", 32'(stage_en), 32'(P_EX));
    #2;
    rst = 1'b0;
    #1;
    chk_all_zero("async_rst");
    #1;
    rst = 1'b1;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fase_decoder.md
Name: fase_decoder

Overview:
- Consumer end of the 5-bit one-hot phase bus driven by the phase counter. Sequence: 00001 IF, 00010 ID, 00100 EX, 01000 MEM, 10000 WB.
- Checks every phase word for legal one-hot encoding and legal successor.
- Issues registered per-stage enable strobes to the datapath and counts retired instructions.
- Supports a halt request/acknowledge handshake that stops issue only at an instruction boundary.

Parameters:
- PHASES, 5, number of phases (width of the one-hot bus); fixed at 5 in this design.
- CNT_W, 16, width of the retire counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_fase  input  5  one-hot phase word from the phase counter.
- halt_req  input  1  level request to stop after the current instruction.
- stage_en  output  5  registered one-hot stage strobe: bit0 IF … bit4 WB.
- retire_cnt  output  CNT_W  count of WB strobes issued.
- halted  output  1  halt acknowledge.
- fase_err  output  1  protocol error flag.
- state_o  output  3  current FSM state, for debug.

Behaviour:
- Reset: rst low at any time, asynchronously:
  - stage_en=0, retire_cnt=0, halted=0, fase_err=0.
  - State=IDLE; internal prev_q=00000.
  - Reset mid-instruction is legal and needs no drain.
- Legality, evaluated each cycle on in_fase:
  - onehot = exactly one bit set.
  - succ_ok = (in_fase == rotl(prev_q)), where rotl(10000)=00001.
  - prev_q <= in_fase every cycle except in ERROR.
- FSM states: IDLE, RUN, HALT_PEND, HALTED, ERROR.
- IDLE:
  - in_fase=00000 is legal: stay.
  - in_fase=00001: go to RUN and issue IF.
  - Any other one-hot word: stay, no error (mid-instruction resync).
  - Non-zero, non-one-hot word: go to ERROR.
- RUN:
  - Legal successor: stage_en <= in_fase.
  - !onehot or !succ_ok: go to ERROR, stage_en <= 0.
  - halt_req=1 on a non-WB cycle: go to HALT_PEND.
  - halt_req=1 on a WB cycle: WB is issued, then go directly to HALTED.
- HALT_PEND:
  - Keeps issuing strobes as in RUN.
  - On the WB cycle: issue WB, then go to HALTED.
  - halt_req dropping before WB does not cancel the halt.
  - Illegal word: go to ERROR; halted is never raised.
- HALTED:
  - halted=1, stage_en=0; phase checking continues.
  - Illegal word: go to ERROR, halted <= 0.
  - halt_req=0: go to IDLE, halted <= 0; resume at the next in_fase=00001.
- ERROR:
  - fase_err=1, stage_en=0, halted=0.
  - Sticky until reset (default build).
- Latency: stage_en lags in_fase by exactly 1 clk. At most one strobe bit is set at any time.
- retire_cnt:
  - +1 on the same edge that registers the WB strobe.
  - Wraps from 2^CNT_W-1 to 0; no saturation.
  - Held in HALTED and ERROR.
- state_o encoding: IDLE=0, RUN=1, HALT_PEND=2, HALTED=3, ERROR=4.

Optional Feature:
- Macro: FASE_DECODER_RECOVER_EN.
- Defined:
  - In ERROR, in_fase=00001 moves to RUN and issues IF.
  - fase_err clears on that same edge.
  - prev_q reloads from in_fase during ERROR.
- Undefined: ERROR is exit-only by reset; prev_q is frozen in ERROR.

Decomposition:
- Package fase_pkg holds:
  - phase constants F_IF=00001, F_ID=00010, F_EX=00100, F_MEM=01000, F_WB=10000.
  - state enum with the fixed encoding above.
  - function fase_rotl.
- One sub-module, fase_legal_chk (combinational):
  - inputs: in_fase, prev_q.
  - outputs: onehot, succ_ok, is_zero, is_wb.
- The FSM, strobe register and counter live in fase_decoder.

Test Plan:
- Reset, then in_fase 00000,00001,00010,00100,01000,10000 repeated 3 times → stage_en equals in_fase delayed 1 clk; retire_cnt=3; fase_err=0.
- halt_req=1 during EX → stage_en MEM then WB; halted=1 the cycle after the WB strobe; stage_en=0 while halted. Drop halt_req → IDLE; issue resumes on the next 00001.
- halt_req=1 on the WB cycle → WB issued; retire_cnt+1; next state HALTED; halted=1.
- RUN, in_fase jumps 00010→01000 → state_o=4; fase_err=1; stage_en=0. Legal words afterwards: stays in ERROR (default). With the macro: next 00001 gives state_o=1 and fase_err=0.
- in_fase=00110 in IDLE → ERROR. in_fase=00100 in IDLE → stays IDLE, no strobe.
- CNT_W=4, 16 full instructions → retire_cnt wraps 15→0. Assert rst low mid-EX → all outputs 0 asynchronously, state_o=0.
